dit_input_reorder: RTL and testbench

//  Input stage of the N-point radix-2 DIT FFT, directly upstream of the stage-1 bfly2 row.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/reorder_bank.sv | 48 ++++
 rtl/dit_input_reorder.sv | 170 +++++++++++++++++
 tb/tb_dit_input_reorder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT datapath: frame geometry,
// complex sample type, FSM state encoding and the index bit-reversal helper.
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int FFT_W     = 3;

    typedef struct packed {
        logic signed [FFT_W-1:0] re;
        logic signed [FFT_W-1:0] im;
    } cplx_t;

    // FILL: storage is being written; DRAIN: storage holds a complete frame
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Reverse the low log2n bits of idx
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned log2n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < log2n; i++) begin
            r = (r << 1) | ((idx >> i) & 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of complex samples: a single natural-order write port and two
// read ports addressed by butterfly index, returning x[br(2k)] and x[br(2k+1)].
module reorder_bank
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [LOG2N-1:0]        waddr,
    input  logic [FFT_W-1:0]        wr_re,
    input  logic [FFT_W-1:0]        wr_im,
    input  logic [LOG2N-2:0]        pair,
    output logic [FFT_W-1:0]        rd0_re,
    output logic [FFT_W-1:0]        rd0_im,
    output logic [FFT_W-1:0]        rd1_re,
    output logic [FFT_W-1:0]        rd1_im
);

    cplx_t            mem [N];
    logic [LOG2N-1:0] ra0;
    logic [LOG2N-1:0] ra1;

    // Read addresses: even and odd natural positions of pair k, bit-reversed
    always_comb begin
        ra0 = LOG2N'(bitrev(32'({pair, 1'b0}), LOG2N));
        ra1 = LOG2N'(bitrev(32'({pair, 1'b1}), LOG2N));
    end

    // Sample store, cleared on reset so idle outputs read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= {wr_re, wr_im};
        end
    end

    assign rd0_re = mem[ra0].re;
    assign rd0_im = mem[ra0].im;
    assign rd1_re = mem[ra1].re;
    assign rd1_im = mem[ra1].im;

endmodule

// File: rtl/dit_input_reorder.sv
// Input reorder stage of the radix-2 DIT FFT. Buffers a natural-order frame
// and presents it as bit-reversed butterfly operand pairs.
// Build option PINGPONG_EN: two banks so one fills while the other drains;
// without it a single bank alternates between FILL and DRAIN.
module dit_input_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int W     = FFT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_re,
    input  logic [W-1:0]       in_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       xr0,
    output logic [W-1:0]       xi0,
    output logic [W-1:0]       xr1,
    output logic [W-1:0]       xi1,
    output logic [LOG2N-2:0]   pair_idx,
    output logic               frame_end
);

    if ((1 << LOG2N) != N || N < 4 || W != FFT_W) begin : g_param_check
        $error("dit_input_reorder: N must equal 2**LOG2N (N >= 4) and W must equal FFT_W");
    end

    logic [1:0]       rst_sync;
    logic             rst_s;
    logic             in_fire;
    logic             out_fire;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-2:0] rd_cnt;
    logic             wr_last;
    logic             rd_last;

    // Reset asserts immediately, releases on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_s = rst_sync[1];

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wr_last   = (wr_cnt == LOG2N'(N - 1));
    assign rd_last   = (rd_cnt == (LOG2N-1)'(N / 2 - 1));
    assign pair_idx  = rd_cnt;
    assign frame_end = out_valid && rd_last;

    // Fill and drain pointers; N is a power of two so both wrap naturally
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (in_fire)  wr_cnt <= wr_cnt + 1'b1;
            if (out_fire) rd_cnt <= rd_cnt + 1'b1;
        end
    end

`ifdef PINGPONG_EN
    state_t     bst    [2];
    state_t     bst_nx [2];
    logic       wr_sel;
    logic       rd_sel;
    logic       rd_free;
    logic [W-1:0] b_r0 [2];
    logic [W-1:0] b_i0 [2];
    logic [W-1:0] b_r1 [2];
    logic [W-1:0] b_i1 [2];

    assign rd_free = out_fire && rd_last;

    // Per-bank state and bank selectors
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            bst[0] <= FILL;
            bst[1] <= FILL;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            bst[0] <= bst_nx[0];
            bst[1] <= bst_nx[1];
            if (in_fire && wr_last) wr_sel <= ~wr_sel;
            if (rd_free)            rd_sel <= ~rd_sel;
        end
    end

    // A bank becomes full on its last write and free on its last read
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bst_nx[b] = bst[b];
            if (rd_free && rd_sel == 1'(b))            bst_nx[b] = FILL;
            if (in_fire && wr_last && wr_sel == 1'(b)) bst_nx[b] = DRAIN;
        end
    end

    // Handshake: a bank freed this cycle can accept a write in the same cycle
    always_comb begin
        out_valid = (bst[rd_sel] == DRAIN);
        in_ready  = (bst[wr_sel] == FILL) || (rd_free && rd_sel == wr_sel);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank #(.N(N), .LOG2N(LOG2N)) u_bank (
            .clk    (clk),
            .rst_n  (rst_s),
            .we     (in_fire && wr_sel == 1'(b)),
            .waddr  (wr_cnt),
            .wr_re  (in_re),
            .wr_im  (in_im),
            .pair   (rd_cnt),
            .rd0_re (b_r0[b]),
            .rd0_im (b_i0[b]),
            .rd1_re (b_r1[b]),
            .rd1_im (b_i1[b])
        );
    end

    assign xr0 = b_r0[rd_sel];
    assign xi0 = b_i0[rd_sel];
    assign xr1 = b_r1[rd_sel];
    assign xi1 = b_i1[rd_sel];
`else
    state_t state;
    state_t state_nx;

    // State register
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) state <= FILL;
        else        state <= state_nx;
    end

    // Full frame moves to DRAIN; last pair consumed returns to FILL
    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (in_fire && wr_last)   state_nx = DRAIN;
            DRAIN:   if (out_fire && rd_last)  state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    // Handshake outputs decoded from state alone
    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == DRAIN);
    end

    reorder_bank #(.N(N), .LOG2N(LOG2N)) u_bank (
        .clk    (clk),
        .rst_n  (rst_s),
        .we     (in_fire),
        .waddr  (wr_cnt),
        .wr_re  (in_re),
        .wr_im  (in_im),
        .pair   (rd_cnt),
        .rd0_re (xr0),
        .rd0_im (xi0),
        .rd1_re (xr1),
        .rd1_im (xi1)
    );
`endif

endmodule

// File: tb/tb_dit_input_reorder.sv
// Directed bench for dit_input_reorder with a scoreboard of expected pairs.
module tb_dit_input_reorder;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [2:0] in_re;
    logic signed [2:0] in_im;
    logic              out_valid;
    logic              out_ready;
    logic signed [2:0] xr0, xi0, xr1, xi1;
    logic [1:0]        pair_idx;
    logic              frame_end;

    dit_input_reorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xr0       (xr0),
        .xi0       (xi0),
        .xr1       (xr1),
        .xi1       (xi1),
        .pair_idx  (pair_idx),
        .frame_end (frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] r0, i0, r1, i1, idx, last;
    } exp_t;

    exp_t              sb [$];
    int                errors = 0;
    int                checks = 0;
    logic signed [2:0] fre [8];
    logic signed [2:0] fim [8];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int br3(input int i);
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
    endfunction

    task automatic push_model();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.r0 = fre[br3(2*k)];
            e.i0 = fim[br3(2*k)];
            e.r1 = fre[br3(2*k+1)];
            e.i1 = fim[br3(2*k+1)];
            e.idx = k;
            e.last = (k == 3) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    task automatic rand_frame();
        for (int s = 0; s < 8; s++) begin
            fre[s] = 3'($urandom_range(0, 7));
            fim[s] = 3'($urandom_range(0, 7));
        end
    endtask

    // Compares every consumed pair with the scoreboard and checks stall stability
    task automatic monitor();
        logic              stalled;
        logic signed [2:0] h0, h1, h2, h3;
        exp_t              e;
        stalled = 1'b0;
        h0 = '0; h1 = '0; h2 = '0; h3 = '0;
        forever begin
            @(negedge clk);
            if (stalled && out_valid) begin
                chk("stall_xr0", xr0, h0);
                chk("stall_xi0", xi0, h1);
                chk("stall_xr1", xr1, h2);
                chk("stall_xi1", xi1, h3);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pair", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("xr0", xr0, e.r0);
                    chk("xi0", xi0, e.i0);
                    chk("xr1", xr1, e.r1);
                    chk("xi1", xi1, e.i1);
                    chk("pair_idx", pair_idx, e.idx);
                    chk("frame_end", frame_end, e.last);
                end
            end
            stalled = out_valid && !out_ready;
            h0 = xr0; h1 = xi0; h2 = xr1; h3 = xi1;
        end
    endtask

    // Feed fre/fim with gap idle cycles between samples; called at posedge+1
    task automatic send(input int gap, output logic ovb, output int stalls);
        int guard;
        stalls = 0;
        ovb = 1'b0;
        for (int s = 0; s < 8; s++) begin
            in_valid = 1'b1;
            in_re = fre[s];
            in_im = fim[s];
            @(negedge clk);
            guard = 0;
            while (!in_ready && guard < 200) begin
                stalls++;
                guard++;
                @(negedge clk);
            end
            if (guard >= 200) chk("in_ready_timeout", 0, 1);
            if (s == 7) ovb = out_valid;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain(input logic [3:0] pat);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            out_ready = pat[k % 4];
            k++;
            @(posedge clk); #1;
        end
        if (sb.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        logic ovb;
        int   st;
        int   tot;
        logic seen;
        exp_t e;
        int   t1r0 [4] = '{-4, -2, -3, -1};
        int   t1r1 [4] = '{0, 2, 1, 3};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        out_ready = 1'b0;
        fork monitor(); join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_xr0", xr0, 0);
        chk("rst_xi0", xi0, 0);
        chk("rst_xr1", xr1, 0);
        chk("rst_xi1", xi1, 0);
        chk("rst_pair_idx", pair_idx, 0);
        chk("rst_frame_end", frame_end, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1: ramp frame, expected pairs taken from the known reordering
        for (int k = 0; k < 8; k++) begin
            fre[k] = 3'(k - 4);
            fim[k] = 3'(3 - k);
        end
        for (int k = 0; k < 4; k++) begin
            e.r0 = t1r0[k];
            e.i0 = -1 - t1r0[k];
            e.r1 = t1r1[k];
            e.i1 = -1 - t1r1[k];
            e.idx = k;
            e.last = (k == 3) ? 1 : 0;
            sb.push_back(e);
        end
        out_ready = 1'b1;
        send(0, ovb, st);
        chk("t1_valid_before_last", ovb, 0);
        drain(4'b1111);

        // 2: same frame, out_ready pattern 1,0,0,1
        push_model();
        out_ready = 1'b0;
        send(0, ovb, st);
        drain(4'b1001);

        // 3: one input every third cycle, latency of out_valid
        rand_frame();
        push_model();
        out_ready = 1'b1;
        send(2, ovb, st);
        chk("t3_valid_at_8th", ovb, 0);
        @(negedge clk);
        chk("t3_valid_after_8th", out_valid, 1);
        @(posedge clk); #1;
        drain(4'b1111);

        // 4: reset after pair 1 is consumed
        rand_frame();
        push_model();
        out_ready = 1'b0;
        send(0, ovb, st);
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_out_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_pair_idx", pair_idx, 0);
        chk("t4_xr1", xr1, 0);
        chk("t4_sb_after_two", sb.size(), 2);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rand_frame();
        push_model();
        out_ready = 1'b1;
        send(0, ovb, st);
        drain(4'b1111);

`ifndef PINGPONG_EN
        // 5: input blocked for the whole drain
        rand_frame();
        push_model();
        out_ready = 1'b0;
        send(0, ovb, st);
        in_valid = 1'b1;
        in_re = 3'sd1;
        in_im = -3'sd1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_in_ready_stalled", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            chk("t5_in_ready_drain", in_ready, 0);
            if (frame_end) seen = 1'b1;
        end
        if (!seen) chk("t5_frame_end_timeout", 0, 1);
        @(negedge clk);
        chk("t5_in_ready_after", in_ready, 1);
        chk("t5_out_valid_after", out_valid, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rand_frame();
        push_model();
        send(0, ovb, st);
        drain(4'b1111);
`else
        // 6: three back-to-back frames through the ping-pong banks
        out_ready = 1'b1;
        tot = 0;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            push_model();
            send(0, ovb, st);
            tot += st;
        end
        chk("t6_in_ready_stalls", tot, 0);
        drain(4'b1111);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
